// File: rtl/oled_char_bridge.sv
// Ibex data-bus slave feeding the OLED character RAM write port and the board LEDs.
// Byte lanes of character stores are queued in a small FIFO and drained one byte per cycle.
module oled_char_bridge #(
    parameter logic [31:0] BASE_ADDR  = 32'h0003_8000,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        data_req_i,
    output logic        data_gnt_o,
    output logic        data_rvalid_o,
    output logic        data_err_o,
    input  logic        data_we_i,
    input  logic [3:0]  data_be_i,
    input  logic [31:0] data_addr_i,
    input  logic [31:0] data_wdata_i,
    output logic [31:0] data_rdata_o,
    output logic        char_we_o,
    output logic [5:0]  char_addr_o,
    output logic [7:0]  char_data_o,
    output logic [7:0]  led_o
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;

    typedef struct packed {
        logic [5:0] addr;
        logic [7:0] data;
    } char_entry_t;

    char_entry_t             mem [FIFO_DEPTH];
    logic [PTR_W-1:0]        wr_ptr;
    logic [PTR_W-1:0]        rd_ptr;
    logic [LVL_W-1:0]        level;

    logic [6:0]              offset;
    logic                    is_led;
    logic                    is_status;
    logic                    is_rsvd;
    logic                    char_wr;
    logic [2:0]              push_count;
    logic [PTR_W-1:0]        lane_slot [4];
    logic                    do_push;
    logic                    do_pop;
    logic                    led_wr;
    logic                    rsp_err;
    logic [31:0]             rsp_rdata;
    logic [31:0]             level_ext;
    logic [3:0]              level_sat;
    logic [LVL_W-1:0]        room;

    // Upper address bits are decoded at top level; the window base is informational here.
    logic unused_bits;
    assign unused_bits = ^{data_addr_i[31:7] ^ BASE_ADDR[31:7]};

    // Address decode, lane slot assignment and grant.
    always_comb begin
        offset     = data_addr_i[6:0];
        is_led     = offset[6] && (offset[5:2] == 4'h0);
        is_status  = offset[6] && (offset[5:2] == 4'h1);
        is_rsvd    = offset[6] && (offset[5:3] != 3'h0);
        char_wr    = data_we_i && !offset[6];
        push_count = 3'd0;
        for (int k = 0; k < 4; k++) begin
            lane_slot[k] = wr_ptr + PTR_W'(push_count);
            if (data_be_i[k]) begin
                push_count = push_count + 3'd1;
            end
        end
        room       = LVL_W'(FIFO_DEPTH) - level;
        data_gnt_o = data_req_i && !rst_i &&
                     (!char_wr || (room >= LVL_W'(push_count)));
        do_push    = data_gnt_o && char_wr;
        do_pop     = (level != '0);
        led_wr     = data_gnt_o && data_we_i && is_led && data_be_i[0];
    end

    // Response payload for the access being granted this cycle.
    always_comb begin
        level_ext = 32'(level);
        level_sat = (level_ext > 32'd15) ? 4'hF : level_ext[3:0];
        rsp_err   = is_rsvd || (is_status && data_we_i);
        rsp_rdata = 32'h0;
        if (!data_we_i) begin
            if (is_led) begin
                rsp_rdata = {24'h0, led_o};
            end else if (is_status) begin
                rsp_rdata = {24'h0, level_sat, 3'b000, (level == '0) && !char_we_o};
            end
        end
    end

    // FIFO storage; writes are gated by the grant, which is low during reset.
    always_ff @(posedge clk_i) begin
        for (int k = 0; k < 4; k++) begin
            if (do_push && data_be_i[k]) begin
                mem[lane_slot[k]] <= '{addr: {data_addr_i[5:2], 2'(k)},
                                       data: data_wdata_i[8*k +: 8]};
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            level         <= '0;
            char_we_o     <= 1'b0;
            char_addr_o   <= 6'h0;
            char_data_o   <= 8'h0;
            led_o         <= 8'h0;
            data_rvalid_o <= 1'b0;
            data_err_o    <= 1'b0;
            data_rdata_o  <= 32'h0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(push_count);
            end
            level <= level + (do_push ? LVL_W'(push_count) : LVL_W'(0))
                           - LVL_W'(do_pop);
            char_we_o <= do_pop;
            if (do_pop) begin
                char_addr_o <= mem[rd_ptr].addr;
                char_data_o <= mem[rd_ptr].data;
                rd_ptr      <= rd_ptr + PTR_W'(1);
            end
            if (led_wr) begin
                led_o <= data_wdata_i[7:0];
            end
            data_rvalid_o <= data_gnt_o;
            data_err_o    <= data_gnt_o && rsp_err;
            data_rdata_o  <= data_gnt_o ? rsp_rdata : 32'h0;
        end
    end

endmodule

// File: tb/tb_oled_char_bridge.sv
// Bench for oled_char_bridge: queue-based reference model checked every cycle plus directed scenarios.
module tb_oled_char_bridge;

    localparam int unsigned DEPTH = 8;
    localparam logic [31:0] BASE  = 32'h0003_8000;

    logic        clk;
    logic        rst;
    logic        req;
    logic        gnt;
    logic        rvalid;
    logic        err;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        char_we;
    logic [5:0]  char_addr;
    logic [7:0]  char_data;
    logic [7:0]  led;

    oled_char_bridge #(.BASE_ADDR(BASE), .FIFO_DEPTH(DEPTH)) dut (
        .clk_i(clk), .rst_i(rst),
        .data_req_i(req), .data_gnt_o(gnt), .data_rvalid_o(rvalid), .data_err_o(err),
        .data_we_i(we), .data_be_i(be), .data_addr_i(addr), .data_wdata_i(wdata),
        .data_rdata_o(rdata),
        .char_we_o(char_we), .char_addr_o(char_addr), .char_data_o(char_data),
        .led_o(led)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    typedef struct packed {
        logic [5:0] a;
        logic [7:0] d;
    } ent_t;

    // Reference model state
    ent_t        mq[$];
    logic        m_char_we;
    logic [5:0]  m_char_addr;
    logic [7:0]  m_char_data;
    logic [7:0]  m_led;
    logic        m_rvalid;
    logic        m_err;
    logic [31:0] m_rdata;

    // Observed logs
    int          ch_cyc[$];
    logic [13:0] ch_val[$];
    int          rs_cyc[$];
    logic        rs_err[$];
    logic [31:0] rs_data[$];

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got 0x%08h expected 0x%08h", name, cyc, act, exp);
        end
    endtask

    function automatic logic model_gnt();
        if (rst || !req) return 1'b0;
        if (we && (addr[6:0] < 7'h40)) return (int'(DEPTH) - mq.size()) >= $countones(be);
        return 1'b1;
    endfunction

    always @(posedge clk) begin : model_b
        logic [6:0]  off;
        logic [31:0] st;
        logic        g;
        int          lvl;
        ent_t        e;
        cyc = cyc + 1;
        if (rst) begin
            mq.delete();
            m_char_we = 0; m_char_addr = 0; m_char_data = 0;
            m_led = 0; m_rvalid = 0; m_err = 0; m_rdata = 0;
        end else begin
            g   = model_gnt();
            off = addr[6:0];
            lvl = mq.size();
            st  = {24'h0, (lvl > 15) ? 4'hF : 4'(lvl), 3'b000, (lvl == 0) && !m_char_we};
            m_rvalid = g;
            m_err    = 1'b0;
            m_rdata  = 32'h0;
            if (mq.size() > 0) begin
                e = mq.pop_front();
                m_char_we = 1'b1; m_char_addr = e.a; m_char_data = e.d;
            end else begin
                m_char_we = 1'b0;
            end
            if (g) begin
                if (off < 7'h40) begin
                    if (we)
                        for (int k = 0; k < 4; k++)
                            if (be[k]) mq.push_back({off[5:2], 2'(k), wdata[8*k +: 8]});
                end else if (off < 7'h44) begin
                    if (we) begin
                        if (be[0]) m_led = wdata[7:0];
                    end else begin
                        m_rdata = {24'h0, m_led};
                    end
                end else if (off < 7'h48) begin
                    if (we) m_err = 1'b1;
                    else    m_rdata = st;
                end else begin
                    m_err = 1'b1;
                end
            end
        end
    end

    // Per-cycle comparison against the model, plus event logging.
    always @(negedge clk) begin
        if (cyc > 0) begin
            check32("gnt", 32'(gnt), 32'(model_gnt()));
            check32("rvalid", 32'(rvalid), 32'(m_rvalid));
            if (m_rvalid) begin
                check32("err", 32'(err), 32'(m_err));
                check32("rdata", rdata, m_rdata);
            end
            check32("char_we", 32'(char_we), 32'(m_char_we));
            check32("char_addr", 32'(char_addr), 32'(m_char_addr));
            check32("char_data", 32'(char_data), 32'(m_char_data));
            check32("led", 32'(led), 32'(m_led));
            if (char_we) begin
                ch_cyc.push_back(cyc);
                ch_val.push_back({char_addr, char_data});
            end
            if (rvalid) begin
                rs_cyc.push_back(cyc);
                rs_err.push_back(err);
                rs_data.push_back(rdata);
            end
        end
    end

    task automatic clear_logs();
        ch_cyc.delete(); ch_val.delete();
        rs_cyc.delete(); rs_err.delete(); rs_data.delete();
    endtask

    task automatic access(input logic w, input logic [3:0] b, input logic [6:0] o,
                          input logic [31:0] d, output int t);
        @(posedge clk); #1;
        req = 1'b1; we = w; be = b; addr = BASE | {25'h0, o}; wdata = d;
        t = -1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (gnt) begin
                t = cyc;
                break;
            end
        end
        if (t < 0) check32("gnt_timeout", 32'(gnt), 32'h1);
    endtask

    task automatic idle();
        @(posedge clk); #1;
        req = 1'b0; we = 1'b0; be = 4'h0; wdata = 32'h0;
    endtask

    task automatic wait_idle();
        logic done;
        done = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk); #1;
            if (mq.size() == 0 && !m_char_we && !char_we) begin
                done = 1'b1;
                break;
            end
        end
        if (!done) check32("drain_timeout", 32'(char_we), 32'h0);
    endtask

    task automatic last_rsp(input string name, input logic e, input logic [31:0] d);
        @(negedge clk); #1;
        check32({name, "_rsp_cnt"}, 32'(rs_cyc.size() > 0), 32'h1);
        if (rs_cyc.size() > 0) begin
            check32({name, "_err"}, 32'(rs_err[$]), 32'(e));
            check32({name, "_rdata"}, rs_data[$], d);
        end
    endtask

    initial begin : stim
        int t, t1, t2, t3;
        logic [13:0] exp_w [4];
        rst = 1'b1; req = 1'b0; we = 1'b0; be = 4'h0; addr = 32'h0; wdata = 32'h0;

        // Request during reset: never granted, never answered
        repeat (2) @(posedge clk);
        #1; req = 1'b1; we = 1'b1; be = 4'hF; addr = BASE | 32'h40; wdata = 32'hFF;
        @(negedge clk);
        check32("rst_gnt", 32'(gnt), 32'h0);
        check32("rst_led", 32'(led), 32'h0);
        check32("rst_char_we", 32'(char_we), 32'h0);
        check32("rst_rvalid", 32'(rvalid), 32'h0);
        check32("rst_rdata", rdata, 32'h0);
        @(posedge clk); #1;
        rst = 1'b0; req = 1'b0; we = 1'b0; be = 4'h0;
        clear_logs();
        repeat (2) @(negedge clk);
        #1;
        check32("rst_no_rsp", 32'(rs_cyc.size()), 32'h0);

        // Word write to cells 4..7
        clear_logs();
        access(1'b1, 4'hF, 7'h04, 32'h4142_4344, t);
        idle();
        wait_idle();
        exp_w = '{{6'd4, 8'h44}, {6'd5, 8'h43}, {6'd6, 8'h42}, {6'd7, 8'h41}};
        check32("sw_rsp_cnt", 32'(rs_cyc.size()), 32'h1);
        if (rs_cyc.size() == 1) begin
            check32("sw_rsp_cyc", 32'(rs_cyc[0]), 32'(t + 1));
            check32("sw_rsp_err", 32'(rs_err[0]), 32'h0);
        end
        check32("sw_strobes", 32'(ch_cyc.size()), 32'h4);
        if (ch_cyc.size() == 4)
            for (int j = 0; j < 4; j++) begin
                check32("sw_strobe_cyc", 32'(ch_cyc[j]), 32'(t + 2 + j));
                check32("sw_strobe_val", 32'(ch_val[j]), 32'(exp_w[j]));
            end

        // Single byte lane 1 at offset 0x0C -> cell 0x0D
        clear_logs();
        access(1'b1, 4'b0010, 7'h0C, 32'h0000_5A00, t);
        idle();
        wait_idle();
        check32("sb_strobes", 32'(ch_cyc.size()), 32'h1);
        if (ch_cyc.size() == 1) begin
            check32("sb_val", 32'(ch_val[0]), 32'({6'h0D, 8'h5A}));
            check32("sb_cyc", 32'(ch_cyc[0]), 32'(t + 2));
        end

        // Backpressure: three back-to-back words
        clear_logs();
        access(1'b1, 4'hF, 7'h00, 32'h6463_6261, t1);
        access(1'b1, 4'hF, 7'h10, 32'h6867_6665, t2);
        access(1'b1, 4'hF, 7'h20, 32'h6C6B_6A69, t3);
        idle();
        wait_idle();
        check32("bp_gnt2", 32'(t2), 32'(t1 + 1));
        check32("bp_gnt3", 32'(t3), 32'(t1 + 5));
        check32("bp_strobes", 32'(ch_cyc.size()), 32'd12);
        if (ch_cyc.size() == 12)
            for (int i = 0; i < 12; i++) begin
                check32("bp_cyc", 32'(ch_cyc[i]), 32'(t1 + 2 + i));
                check32("bp_val", 32'(ch_val[i]),
                        32'({6'((i / 4) * 16 + (i % 4)), 8'(8'h61 + i)}));
            end

        // LED write, readback, and ignored upper lane
        clear_logs();
        access(1'b1, 4'b0001, 7'h40, 32'h0000_00A5, t);
        idle();
        @(negedge clk);
        check32("led_t1_cyc", 32'(cyc), 32'(t + 1));
        check32("led_t1", 32'(led), 32'hA5);
        access(1'b0, 4'hF, 7'h40, 32'h0, t);
        idle();
        last_rsp("led_rd", 1'b0, 32'h0000_00A5);
        access(1'b1, 4'b0010, 7'h40, 32'h0000_3C00, t);
        idle();
        @(negedge clk);
        check32("led_be1", 32'(led), 32'hA5);

        // Errors and status
        access(1'b0, 4'hF, 7'h50, 32'h0, t);
        idle();
        last_rsp("rsvd_rd", 1'b1, 32'h0);
        access(1'b1, 4'hF, 7'h44, 32'hFFFF_FFFF, t);
        idle();
        last_rsp("status_wr", 1'b1, 32'h0);
        wait_idle();
        access(1'b0, 4'hF, 7'h44, 32'h0, t);
        idle();
        last_rsp("status_idle", 1'b0, 32'h0000_0001);
        access(1'b1, 4'hF, 7'h08, 32'h3031_3233, t);
        access(1'b0, 4'hF, 7'h44, 32'h0, t);
        idle();
        last_rsp("status_busy", 1'b0, 32'h0000_0040);
        wait_idle();

        // Reset in the middle of a drain
        clear_logs();
        access(1'b1, 4'hF, 7'h14, 32'h3534_3332, t);
        idle();
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check32("rmd_cyc", 32'(cyc), 32'(t + 4));
        check32("rmd_char_we", 32'(char_we), 32'h0);
        check32("rmd_led", 32'(led), 32'h0);
        wait_idle();
        check32("rmd_strobes", 32'(ch_cyc.size()), 32'h2);
        if (ch_cyc.size() == 2) begin
            check32("rmd_cyc0", 32'(ch_cyc[0]), 32'(t + 2));
            check32("rmd_val0", 32'(ch_val[0]), 32'({6'd20, 8'h32}));
            check32("rmd_val1", 32'(ch_val[1]), 32'({6'd21, 8'h33}));
        end
        access(1'b0, 4'hF, 7'h44, 32'h0, t);
        idle();
        last_rsp("rmd_status", 1'b0, 32'h0000_0001);

        repeat (3) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not complete, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/oled_char_bridge.md
# oled_char_bridge

Memory-mapped slave on the Ibex data bus that sits directly upstream of the OLED character RAM write port and the board LEDs. It accepts word, halfword and byte stores into a 64-cell character window and serialises every enabled byte lane into single-byte RAM writes through a small FIFO. It applies grant backpressure when the FIFO lacks room. It also holds the LED register and a readable status word, and returns an rvalid, with error where applicable, for every granted access.

## Interface
- `BASE_ADDR`, default 32'h0003_8000: window base, 128-byte aligned.
- `FIFO_DEPTH`, default 8: byte-entry FIFO depth; power of two, at least 4.
- `clk_i` in 1: system clock; the block uses this single clock.
- `rst_i` in 1: reset, synchronous and active-high.
- `data_req_i` in 1: bus request, already qualified by top-level decode as data_addr_i[31:7] == BASE_ADDR[31:7].
- `data_gnt_o` out 1: grant, combinational.
- `data_rvalid_o` out 1: response valid.
- `data_err_o` out 1: response error; meaningful only while data_rvalid_o is high.
- `data_we_i` in 1: write enable.
- `data_be_i` in 4: byte enables.
- `data_addr_i` in 32: byte address; only bits [6:0] are used.
- `data_wdata_i` in 32: write data.
- `data_rdata_o` out 32: read data.
- `char_we_o` out 1: character RAM write strobe, one byte per cycle.
- `char_addr_o` out 6: character cell index.
- `char_data_o` out 8: ASCII byte.
- `led_o` out 8: LED register.

## Operation
- Offset map, using addr[6:0]:
  - 0x00–0x3F: character cells, write-only; reads return 0.
  - 0x40: LED register, R/W, byte lane 0 only.
  - 0x44: STATUS, read-only.
  - 0x48–0x7F: reserved; any access completes with an error.
- Grant rule:
  - data_gnt_o = data_req_i, except for a character write.
  - A character write is granted only when `FIFO_DEPTH − level ≥ popcount(data_be_i)`.
  - All other accesses always grant in the request cycle.
- Character write (granted):
  - Every enabled lane k pushes one entry {addr = {addr[5:2], k[1:0]}, data = wdata[8k+7:8k]}.
  - Lanes are pushed in ascending k order, with up to 4 pushes in one cycle.
  - be = 0 pushes nothing but still responds.
- Drain:
  - At each clock edge, if level > 0, the head is popped into registered char_we_o/char_addr_o/char_data_o with char_we_o = 1.
  - Otherwise char_we_o = 0; char_addr_o and char_data_o hold their values.
- Level update on the same edge: `level_next = level + pushes − pop`. A simultaneous push and pop is legal, including when level is at FIFO_DEPTH.
- LED register:
  - A write to 0x40 with be[0] = 1 loads wdata[7:0]. Other lanes are ignored.
  - A read returns {24'b0, led_o}.
- STATUS read:
  - Bit 0: empty, = (level == 0 && !char_we_o).
  - Bits [7:4]: level, saturating at 15.
  - All other bits read 0.
- Errors:
  - A write to 0x44, or any access to 0x48–0x7F, gives err = 1 and rdata = 0.
  - Such an access has no side effects.
- Response: every granted access yields exactly one rvalid. Writes return rdata = 0.

## Timing
- Grant cycle T. data_rvalid_o, data_err_o and data_rdata_o are registered and high/valid for exactly cycle T+1.
- Back-to-back granted requests produce back-to-back rvalids.
- Character write starting from an empty FIFO:
  - First byte strobe at T+2.
  - Each further byte follows on consecutive cycles.
  - A full word finishes at T+5.
- Sustained throughput is 1 byte/cycle. With FIFO_DEPTH = 8, two back-to-back full-word stores fill the FIFO.
- An LED write is visible on led_o from T+1.
- Reset (rst_i high at an edge):
  - Outputs: data_rvalid_o = 0, data_err_o = 0, data_rdata_o = 0, char_we_o = 0, char_addr_o = 0, char_data_o = 0, led_o = 0.
  - State: level = 0; pending FIFO entries are discarded.
  - data_gnt_o is forced to 0 while rst_i is high.
  - A request presented during reset is neither granted nor answered.
- Reset mid-drain truncates the store. Remaining bytes are never written.

## Test plan
- Word write: sw 0x41424344 to offset 0x04, be = 1111, at T.
  - rvalid at T+1 with err = 0.
  - char writes (4,0x44), (5,0x43), (6,0x42), (7,0x41) at T+2 through T+5.
- Byte write: sb with be = 0010, data 0x00005A00, offset 0x0C.
  - Exactly one char write (0x0D, 0x5A).
  - char_we_o low before and after it.
- Backpressure: three consecutive sw be = 1111 while data_req_i is held.
  - First two grant in consecutive cycles.
  - Third grant waits until level ≤ 4.
  - Exactly 12 strobes appear, in order, with no gaps once draining starts.
- LED: write 0xA5 to 0x40 with be = 0001, then read 0x40.
  - led_o = 0xA5 from T+1.
  - Read returns rdata = 0x000000A5.
  - A write with be = 0010 leaves led_o unchanged.
- Errors/status:
  - Read 0x50 gives rvalid with err = 1 and rdata = 0.
  - Write to 0x44 gives err = 1.
  - Idle STATUS read returns 0x00000001.
  - STATUS read immediately after a granted sw returns level 4 and empty = 0.
- Reset mid-drain: sw be = 1111 at T, rst_i high at T+3.
  - char_we_o = 0 from T+4.
  - Only 2 bytes are written.
  - led_o = 0.
  - A subsequent STATUS read returns 0x00000001.
